// File: rtl/data_bus_responder_pkg.sv
// data_bus_responder_pkg: shared widths, default bases,
// MMIO register offsets and status bit positions.
package data_bus_responder_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] MMIO_BYTES    = 32'd32;

  typedef enum logic [2:0] {
    MMIO_OFF_MTIME_LO = 3'd0,
    MMIO_OFF_MTIME_HI = 3'd1,
    MMIO_OFF_CMP_LO   = 3'd2,
    MMIO_OFF_CMP_HI   = 3'd3,
    MMIO_OFF_TOHOST   = 3'd4,
    MMIO_OFF_STATUS   = 3'd5
  } mmio_off_e;

  localparam int STAT_IRQ  = 0;
  localparam int STAT_HALT = 1;
  localparam int STAT_BERR = 2;

  function automatic logic [DATA_WIDTH-1:0] status_word(
    input logic irq,
    input logic halt,
    input logic berr
  );
    logic [DATA_WIDTH-1:0] w;
    w            = '0;
    w[STAT_IRQ]  = irq;
    w[STAT_HALT] = halt;
    w[STAT_BERR] = berr;
    return w;
  endfunction

endpackage

// File: rtl/data_bus_responder_mtimer.sv
// mtimer: prescaled 64-bit mtime, mtimecmp, registered irq.
// Ports: clk, rst, half-word write strobes + wdata,
//        mtime/mtimecmp (to read mux), timer_irq.
module mtimer
  import data_bus_responder_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_lo,
  input  logic                  we_hi,
  input  logic                  we_cmp_lo,
  input  logic                  we_cmp_hi,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [63:0]           mtime,
  output logic [63:0]           mtimecmp,
  output logic                  timer_irq
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      // software write to either half suppresses the tick
      if (we_lo)
        mtime[31:0] <= wdata;
      if (we_hi)
        mtime[63:32] <= wdata;
      if (!(we_lo || we_hi) && tick)
        mtime <= mtime + 64'd1;
      if (we_cmp_lo)
        mtimecmp[31:0] <= wdata;
      if (we_cmp_hi)
        mtimecmp[63:32] <= wdata;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-memory port responder with RAM + MMIO.
// Ports: clk, rst, ram_we/address/wdata in, ram_rdata (comb),
//        timer_irq, sim_halt, halt_code, bus_err out.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
  parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
  parameter int          TICK_DIV  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_we,
  input  logic [BUS_WIDTH-1:0]  ram_address,
  input  logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  timer_irq,
  output logic                  sim_halt,
  output logic [DATA_WIDTH-1:0] halt_code,
  output logic                  bus_err
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [BUS_WIDTH-1:0] RAM_BYTES =
    BUS_WIDTH'(4 * RAM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [BUS_WIDTH-1:0]  ram_off;
  logic [BUS_WIDTH-1:0]  mmio_off;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic [AW-1:0]         word_idx;
  mmio_off_e             reg_off;

  logic                  mmio_we;
  logic                  tohost_we;
  logic                  berr_set;
  logic                  berr_clr;
  logic [DATA_WIDTH-1:0] tohost;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;

  // offset-from-base compare: one unsigned test covers both bounds
  assign ram_off  = ram_address - RAM_BASE;
  assign mmio_off = ram_address - MMIO_BASE;
  assign ram_hit  = (ram_off < RAM_BYTES);
  assign mmio_hit = (mmio_off < MMIO_BYTES);
  assign word_idx = ram_off[AW+1:2];
  assign reg_off  = mmio_off_e'(mmio_off[4:2]);

  assign mmio_we   = ram_we && mmio_hit;
  assign tohost_we = mmio_we && (reg_off == MMIO_OFF_TOHOST);
  assign berr_set  = ram_we && !ram_hit && !mmio_hit;
  assign berr_clr  = mmio_we && (reg_off == MMIO_OFF_STATUS)
                     && ram_wdata[STAT_BERR];

  mtimer #(
    .TICK_DIV (TICK_DIV)
  ) u_mtimer (
    .clk       (clk),
    .rst       (rst),
    .we_lo     (mmio_we && (reg_off == MMIO_OFF_MTIME_LO)),
    .we_hi     (mmio_we && (reg_off == MMIO_OFF_MTIME_HI)),
    .we_cmp_lo (mmio_we && (reg_off == MMIO_OFF_CMP_LO)),
    .we_cmp_hi (mmio_we && (reg_off == MMIO_OFF_CMP_HI)),
    .wdata     (ram_wdata),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .timer_irq (timer_irq)
  );

  always_ff @(posedge clk) begin
    if (!rst && ram_we && ram_hit)
      mem[word_idx] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost    <= '0;
      sim_halt  <= 1'b0;
      halt_code <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (tohost_we) begin
        tohost <= ram_wdata;
        // only the first nonzero write latches the exit code
        if (ram_wdata != '0 && !sim_halt) begin
          sim_halt  <= 1'b1;
          halt_code <= ram_wdata;
        end
      end
      if (berr_set)
        bus_err <= 1'b1;
      else if (berr_clr)
        bus_err <= 1'b0;
    end
  end

  always_comb begin
    ram_rdata = '0;
    unique case (1'b1)
      ram_hit:
        ram_rdata = mem[word_idx];
      mmio_hit:
        case (reg_off)
          MMIO_OFF_MTIME_LO: ram_rdata = mtime[31:0];
          MMIO_OFF_MTIME_HI: ram_rdata = mtime[63:32];
          MMIO_OFF_CMP_LO:   ram_rdata = mtimecmp[31:0];
          MMIO_OFF_CMP_HI:   ram_rdata = mtimecmp[63:32];
          MMIO_OFF_TOHOST:   ram_rdata = tohost;
          MMIO_OFF_STATUS:
            ram_rdata = status_word(timer_irq, sim_halt, bus_err);
          default:           ram_rdata = '0;
        endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: vector table + directed timer,
// irq and async-reset sequences for data_bus_responder.
module tb_data_bus_responder;

  localparam logic [31:0] MT_LO  = 32'h1000_0000;
  localparam logic [31:0] MT_HI  = 32'h1000_0004;
  localparam logic [31:0] CMP_LO = 32'h1000_0008;
  localparam logic [31:0] CMP_HI = 32'h1000_000C;
  localparam logic [31:0] TOHOST = 32'h1000_0010;
  localparam logic [31:0] STATUS = 32'h1000_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_we = 1'b0;
  logic [31:0] ram_address = '0;
  logic [31:0] ram_wdata = '0;
  logic [31:0] ram_rdata;
  logic        timer_irq;
  logic        sim_halt;
  logic [31:0] halt_code;
  logic        bus_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] rd;
    logic        halt;
    logic        berr;
  } vec_t;

  vec_t vecs[$];

  data_bus_responder dut (
    .clk         (clk),
    .rst         (rst),
    .ram_we      (ram_we),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .timer_irq   (timer_irq),
    .sim_halt    (sim_halt),
    .halt_code   (halt_code),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic c,
                     input logic [31:0] rd, input logic halt,
                     input logic berr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.chk = c;
    v.rd = rd; v.halt = halt; v.berr = berr;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ram_we = 1'b1; ram_address = a; ram_wdata = d;
    step();
    ram_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    ram_address = a;
    #1;
    d = ram_rdata;
  endtask

  initial begin
    logic [31:0] d;
    bit found;

    add(1, 32'h40,   32'h1111_1111, 0, 0, 0, 0);
    add(1, 32'h40,   32'hDEAD_BEEF, 1, 32'h1111_1111, 0, 0);
    add(0, 32'h40,   0, 1, 32'hDEAD_BEEF, 0, 0);
    add(0, 32'h42,   0, 1, 32'hDEAD_BEEF, 0, 0);
    add(0, 32'h43,   0, 1, 32'hDEAD_BEEF, 0, 0);
    add(1, 32'h3FFC, 32'hCAFE_F00D, 0, 0, 0, 0);
    add(0, 32'h3FFC, 0, 1, 32'hCAFE_F00D, 0, 0);
    add(0, 32'h4000, 0, 1, 0, 0, 0);
    add(1, CMP_LO,   32'h1234_5678, 0, 0, 0, 0);
    add(0, CMP_LO,   0, 1, 32'h1234_5678, 0, 0);
    add(0, CMP_HI,   0, 1, 32'hFFFF_FFFF, 0, 0);
    add(1, TOHOST,   0, 1, 0, 0, 0);
    add(0, STATUS,   0, 1, 0, 0, 0);
    add(1, TOHOST,   1, 1, 0, 1, 0);
    add(0, STATUS,   0, 1, 2, 1, 0);
    add(1, TOHOST,   5, 1, 1, 1, 0);
    add(0, TOHOST,   0, 1, 5, 1, 0);
    add(0, 32'h1000_0018, 0, 1, 0, 1, 0);
    add(0, 32'h1000_001C, 0, 1, 0, 1, 0);
    add(0, 32'h1000_0020, 0, 1, 0, 1, 0);
    add(0, 32'h0FFF_FFFC, 0, 1, 0, 1, 0);
    add(1, 32'h2000_0000, 32'h55, 1, 0, 1, 1);
    add(0, STATUS,   0, 1, 6, 1, 1);
    add(0, 32'h40,   0, 1, 32'hDEAD_BEEF, 1, 1);
    add(0, TOHOST,   0, 1, 5, 1, 1);
    add(1, STATUS,   3, 1, 6, 1, 1);
    add(1, STATUS,   4, 1, 6, 1, 0);
    add(0, STATUS,   0, 1, 2, 1, 0);
    add(1, 32'h4000, 32'h77, 1, 0, 1, 1);
    add(0, 32'h3FFC, 0, 1, 32'hCAFE_F00D, 1, 1);
    add(1, STATUS,   32'hFFFF_FFFF, 1, 6, 1, 0);
    add(0, STATUS,   0, 1, 2, 1, 0);

    // reset state, sampled while rst is held
    step(); step();
    rd(STATUS, d); chk("rst status", d, 0);
    rd(MT_LO, d);  chk("rst mtime_lo", d, 0);
    rd(CMP_LO, d); chk("rst cmp_lo", d, 32'hFFFF_FFFF);
    rd(CMP_HI, d); chk("rst cmp_hi", d, 32'hFFFF_FFFF);
    chk("rst halt_code", halt_code, 0);
    chk("rst irq", {31'b0, timer_irq}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      ram_we = vecs[i].we;
      ram_address = vecs[i].addr;
      ram_wdata = vecs[i].wdata;
      #1;
      if (vecs[i].chk)
        chk($sformatf("v%0d rdata", i), ram_rdata, vecs[i].rd);
      step();
      chk($sformatf("v%0d halt", i), {31'b0, sim_halt},
          {31'b0, vecs[i].halt});
      chk($sformatf("v%0d berr", i), {31'b0, bus_err},
          {31'b0, vecs[i].berr});
    end
    ram_we = 1'b0;
    chk("halt_code sticky", halt_code, 1);

    // 64-bit carry and write-over-increment
    wr(MT_LO, 32'hFFFF_FFFE);
    wr(MT_HI, 0);
    rd(MT_LO, d); chk("carry hold", d, 32'hFFFF_FFFE);
    step();
    rd(MT_LO, d); chk("carry lo1", d, 32'hFFFF_FFFF);
    step();
    rd(MT_LO, d); chk("carry lo2", d, 0);
    rd(MT_HI, d); chk("carry hi2", d, 1);
    wr(MT_LO, 100);
    rd(MT_LO, d); chk("wr wins lo", d, 100);
    rd(MT_HI, d); chk("wr wins hi", d, 1);
    step();
    rd(MT_LO, d); chk("after wr lo", d, 101);

    // irq latency and drop
    wr(CMP_LO, 10);
    wr(MT_HI, 0);
    wr(MT_LO, 0);
    wr(CMP_HI, 0);
    chk("irq idle", {31'b0, timer_irq}, 0);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      rd(MT_LO, d);
      if (d == 10) begin
        found = 1;
        break;
      end
      step();
    end
    chk("irq reach10", {31'b0, found}, 1);
    chk("irq pre", {31'b0, timer_irq}, 0);
    step();
    chk("irq rise", {31'b0, timer_irq}, 1);
    rd(STATUS, d); chk("irq status", d, 3);
    wr(CMP_HI, 1);
    chk("irq hold", {31'b0, timer_irq}, 1);
    step();
    chk("irq drop", {31'b0, timer_irq}, 0);

    // async reset mid-count
    wr(32'h80, 32'h1212_1212);
    wr(MT_LO, 37);
    rd(MT_LO, d); chk("pre rst mtime", d, 37);
    rst = 1'b1;
    #1;
    rd(MT_LO, d);  chk("arst mtime", d, 0);
    rd(CMP_HI, d); chk("arst cmp_hi", d, 32'hFFFF_FFFF);
    rd(CMP_LO, d); chk("arst cmp_lo", d, 32'hFFFF_FFFF);
    chk("arst halt", {31'b0, sim_halt}, 0);
    chk("arst code", halt_code, 0);
    chk("arst irq", {31'b0, timer_irq}, 0);
    ram_we = 1'b1;
    ram_address = 32'h80;
    ram_wdata = 32'hAAAA_5555;
    step(); step();
    ram_we = 1'b0;
    rst = 1'b0;
    rd(32'h80, d); chk("rst ram wr", d, 32'h1212_1212);
    rd(TOHOST, d); chk("rst tohost", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
